// File: rtl/s2r_pkg.sv
// Shared derivations for the s2r row packer: beat count, beat width, counter widths
// and the row/beat divisibility check.
package s2r_pkg;

    function automatic int beats_f(input int col, input int in_elems);
        return col / in_elems;
    endfunction

    function automatic int beat_w_f(input int width, input int in_elems);
        return width * in_elems;
    endfunction

    // Counters never shrink below one bit so a degenerate count still has a register.
    function automatic int cnt_w_f(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic bit col_legal_f(input int col, input int in_elems);
        return (in_elems > 0) && ((col % in_elems) == 0);
    endfunction

endpackage

// File: rtl/s2r_row_bank.sv
// One row register of the ping-pong pair plus its full flag. A beat write at index k
// lands MSB-first; zero-fill clears every beat after the written one.
module s2r_row_bank
    import s2r_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int COL      = 256,
    parameter int IN_ELEMS = 4,
    parameter int BEATS    = beats_f(COL, IN_ELEMS),
    parameter int BW       = beat_w_f(WIDTH, IN_ELEMS),
    parameter int IDX_W    = cnt_w_f(BEATS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en_i,
    input  logic [IDX_W-1:0]     wr_idx_i,
    input  logic [BW-1:0]        wr_data_i,
    input  logic                 zfill_i,
    input  logic                 set_full_i,
    input  logic                 clr_full_i,
    output logic [WIDTH*COL-1:0] row_o,
    output logic                 full_o
);

    logic [BEATS-1:0][BW-1:0] row_q, row_d;
    logic                     full_q, full_d;

    always_comb begin
        row_d  = row_q;
        full_d = full_q;
        for (int b = 0; b < BEATS; b++) begin
            if (wr_en_i && (wr_idx_i == IDX_W'(b)))
                row_d[BEATS-1-b] = wr_data_i;
            else if (wr_en_i && zfill_i && (IDX_W'(b) > wr_idx_i))
                row_d[BEATS-1-b] = '0;
        end
        if (clr_full_i) full_d = 1'b0;
        if (set_full_i) full_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_q  <= '0;
            full_q <= 1'b0;
        end else begin
            row_q  <= row_d;
            full_q <= full_d;
        end
    end

    assign row_o  = row_q;
    assign full_o = full_q;

endmodule

// File: rtl/s2r_row_packer.sv
// Packs IN_ELEMS-wide beats into COL-element rows through two ping-pong banks.
// Optional S2R_LAST_CHECK_EN: checks s_last framing, zero-fills early rows, flags err_last.
module s2r_row_packer
    import s2r_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int COL      = 256,
    parameter int ROW      = 2754,
    parameter int IN_ELEMS = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [WIDTH*IN_ELEMS-1:0]     s_data,
    input  logic                          s_last,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WIDTH*COL-1:0]          out_row,
    output logic                          matrix_done,
    output logic                          err_last
);

    localparam int BEATS = beats_f(COL, IN_ELEMS);
    localparam int BW    = beat_w_f(WIDTH, IN_ELEMS);
    localparam int BC_W  = cnt_w_f(BEATS);
    localparam int RC_W  = cnt_w_f(ROW);

    if (!col_legal_f(COL, IN_ELEMS)) begin : g_bad_col
        $error("s2r_row_packer: COL must be a multiple of IN_ELEMS");
    end

    logic                          wr_sel_q, wr_sel_d, rd_sel_q, rd_sel_d;
    logic [BC_W-1:0]               beat_cnt_q, beat_cnt_d;
    logic [RC_W-1:0]               row_cnt_q, row_cnt_d;
    logic [1:0]                    full;
    logic [1:0][WIDTH*COL-1:0]     bank_row;
    logic                          accept, last_beat, row_done, zfill, hs;

    assign s_ready   = !rst && !full[wr_sel_q];
    assign accept    = s_valid && s_ready;
    assign last_beat = (beat_cnt_q == BC_W'(BEATS-1));
    assign out_valid = !rst && full[rd_sel_q];
    assign out_row   = rst ? '0 : bank_row[rd_sel_q];
    assign hs        = out_valid && out_ready;
    assign matrix_done = hs && (row_cnt_q == RC_W'(ROW-1));

`ifdef S2R_LAST_CHECK_EN
    logic err_q, err_d;
    // An early s_last closes the row at once; any framing mismatch sticks until reset.
    assign zfill    = s_last && !last_beat;
    assign row_done = accept && (last_beat || s_last);
    assign err_d    = err_q | (accept && (s_last != last_beat));
    always_ff @(posedge clk) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end
    assign err_last = err_q;
`else
    logic unused_s_last;
    assign unused_s_last = s_last;
    assign zfill    = 1'b0;
    assign row_done = accept && last_beat;
    assign err_last = 1'b0;
`endif

    always_comb begin
        beat_cnt_d = beat_cnt_q;
        wr_sel_d   = wr_sel_q;
        rd_sel_d   = rd_sel_q;
        row_cnt_d  = row_cnt_q;
        if (accept) begin
            beat_cnt_d = row_done ? '0 : beat_cnt_q + 1'b1;
            if (row_done) wr_sel_d = ~wr_sel_q;
        end
        if (hs) begin
            rd_sel_d  = ~rd_sel_q;
            row_cnt_d = (row_cnt_q == RC_W'(ROW-1)) ? '0 : row_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_sel_q   <= 1'b0;
            rd_sel_q   <= 1'b0;
            beat_cnt_q <= '0;
            row_cnt_q  <= '0;
        end else begin
            wr_sel_q   <= wr_sel_d;
            rd_sel_q   <= rd_sel_d;
            beat_cnt_q <= beat_cnt_d;
            row_cnt_q  <= row_cnt_d;
        end
    end

    for (genvar i = 0; i < 2; i++) begin : g_bank
        s2r_row_bank #(
            .WIDTH    (WIDTH),
            .COL      (COL),
            .IN_ELEMS (IN_ELEMS)
        ) u_bank (
            .clk        (clk),
            .rst        (rst),
            .wr_en_i    (accept && (wr_sel_q == 1'(i))),
            .wr_idx_i   (beat_cnt_q),
            .wr_data_i  (s_data),
            .zfill_i    (zfill),
            .set_full_i (row_done && (wr_sel_q == 1'(i))),
            .clr_full_i (hs && (rd_sel_q == 1'(i))),
            .row_o      (bank_row[i]),
            .full_o     (full[i])
        );
    end

endmodule
